galaksija_keyboard: RTL

Serial-to-matrix keyboard stage for the Galaksija core. It sits downstream of `uart_rx` and upstream of the CPU read mux. Received ASCII bytes are queued, then replayed one at a time as timed key presses on a virtual 64-key Galaksija matrix. Each press is followed by a forced release gap, so that repeated characters and fast pasted text are seen by the ROM keyboard scan as distinct keystrokes.

---
 rtl/galaksija_keyboard.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/galaksija_keyboard.sv
// Serial-to-matrix keyboard: queued ASCII bytes replayed as timed presses on the 64-key Galaksija matrix.
// Define KBD_FIFO_EN for a fifo_depth-entry byte queue; otherwise a single-byte holding register is used.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a queued byte; pops it as soon as one exists
// DECODE | maps the popped byte to a key index and shift flag
// PRESS  | key (and shift) held down for hold_cycles
// GAP    | all keys released for gap_cycles
module galaksija_keyboard #(
    parameter int unsigned f_clk      = 25000000,
    parameter int unsigned hold_ms    = 40,
    parameter int unsigned gap_ms     = 20,
    parameter int unsigned fifo_depth = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rd_key,
    input  logic [5:0] key_addr,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam logic [31:0] hold_raw    = 32'(f_clk / 1000 * hold_ms);
    localparam logic [31:0] gap_raw     = 32'(f_clk / 1000 * gap_ms);
    localparam logic [31:0] hold_cycles = (hold_raw == 32'd0) ? 32'd1 : hold_raw;
    localparam logic [31:0] gap_cycles  = (gap_raw == 32'd0) ? 32'd1 : gap_raw;
    localparam logic [5:0]  shift_key   = 6'd53;

    if (fifo_depth < 2 || fifo_depth > 256 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
        $error("galaksija_keyboard: fifo_depth must be a power of two in 2..256");
    end

    typedef enum logic [1:0] {IDLE, DECODE, PRESS, GAP} state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [7:0]  cur_byte;
    logic [5:0]  key_idx;
    logic        key_shift;
    logic        key_active;

    logic       q_full, q_empty, q_full_next, q_empty_next;
    logic [7:0] q_head;
    logic       push, pop, drop;

    assign pop  = (state == IDLE) && !q_empty;
    assign push = rx_valid && (!q_full || pop);
    assign drop = rx_valid && q_full && !pop;

`ifdef KBD_FIFO_EN
    localparam int aw = $clog2(fifo_depth);
    localparam logic [aw:0] depth_c = (aw + 1)'(fifo_depth);

    logic [7:0]    mem [fifo_depth];
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [aw:0]   count, count_next;

    assign count_next   = count + {{aw{1'b0}}, push} - {{aw{1'b0}}, pop};
    assign q_full       = (count == depth_c);
    assign q_empty      = (count == '0);
    assign q_full_next  = (count_next == depth_c);
    assign q_empty_next = (count_next == '0);
    assign q_head       = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end
`else
    logic [7:0] hold_reg;
    logic       occupied, occupied_next;

    // A push in the same cycle as a pop refills the register immediately.
    assign occupied_next = push || (occupied && !pop);
    assign q_full        = occupied;
    assign q_empty       = !occupied;
    assign q_full_next   = occupied_next;
    assign q_empty_next  = !occupied_next;
    assign q_head        = hold_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_reg <= 8'h00;
            occupied <= 1'b0;
        end else begin
            if (push) hold_reg <= rx_data;
            occupied <= occupied_next;
        end
    end
`endif

    logic       dec_valid, dec_shift;
    logic [5:0] dec_key;

    always_comb begin
        dec_valid = 1'b1;
        dec_shift = 1'b0;
        dec_key   = 6'd0;
        if ((cur_byte >= "A" && cur_byte <= "Z") || (cur_byte >= "a" && cur_byte <= "z")) begin
            dec_key = {1'b0, cur_byte[4:0]};
        end else if (cur_byte >= "0" && cur_byte <= "9") begin
            dec_key = {2'b10, cur_byte[3:0]};
        end else begin
            case (cur_byte)
                8'h0A, 8'h0D: dec_key = 6'd48;
                8'h08, 8'h7F: dec_key = 6'd29;
                8'h1B:        dec_key = 6'd49;
                " ":          dec_key = 6'd31;
                ";":          dec_key = 6'd42;
                ":":          dec_key = 6'd43;
                ",":          dec_key = 6'd44;
                "=":          dec_key = 6'd45;
                ".":          dec_key = 6'd46;
                "/":          dec_key = 6'd47;
                "_":          begin dec_key = 6'd32; dec_shift = 1'b1; end
                "!":          begin dec_key = 6'd33; dec_shift = 1'b1; end
                "\"":         begin dec_key = 6'd34; dec_shift = 1'b1; end
                "#":          begin dec_key = 6'd35; dec_shift = 1'b1; end
                "$":          begin dec_key = 6'd36; dec_shift = 1'b1; end
                "%":          begin dec_key = 6'd37; dec_shift = 1'b1; end
                "&":          begin dec_key = 6'd38; dec_shift = 1'b1; end
                "\\":         begin dec_key = 6'd39; dec_shift = 1'b1; end
                "(":          begin dec_key = 6'd40; dec_shift = 1'b1; end
                ")":          begin dec_key = 6'd41; dec_shift = 1'b1; end
                "+":          begin dec_key = 6'd42; dec_shift = 1'b1; end
                "*":          begin dec_key = 6'd43; dec_shift = 1'b1; end
                "<":          begin dec_key = 6'd44; dec_shift = 1'b1; end
                "-":          begin dec_key = 6'd45; dec_shift = 1'b1; end
                ">":          begin dec_key = 6'd46; dec_shift = 1'b1; end
                "?":          begin dec_key = 6'd47; dec_shift = 1'b1; end
                default:      dec_valid = 1'b0;
            endcase
        end
    end

    // busy is registered from the values this edge commits, so it always matches the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 32'd0;
            cur_byte   <= 8'h00;
            key_idx    <= 6'd0;
            key_shift  <= 1'b0;
            key_active <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        cur_byte <= q_head;
                        state    <= DECODE;
                        busy     <= 1'b1;
                    end else begin
                        busy <= !q_empty_next;
                    end
                end
                DECODE: begin
                    if (dec_valid) begin
                        key_idx    <= dec_key;
                        key_shift  <= dec_shift;
                        key_active <= 1'b1;
                        cnt        <= hold_cycles - 32'd1;
                        state      <= PRESS;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= !q_empty_next;
                    end
                end
                PRESS: begin
                    busy <= 1'b1;
                    if (cnt == 32'd0) begin
                        key_active <= 1'b0;
                        cnt        <= gap_cycles - 32'd1;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                GAP: begin
                    if (cnt == 32'd0) begin
                        state <= IDLE;
                        busy  <= !q_empty_next;
                    end else begin
                        cnt  <= cnt - 32'd1;
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    key_active <= 1'b0;
                    busy       <= !q_empty_next;
                end
            endcase
        end
    end

    logic key_hit;
    assign key_hit = key_active && ((key_addr == key_idx) || (key_shift && key_addr == shift_key));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_out   <= 8'hFF;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (rd_key) key_out <= key_hit ? 8'hFE : 8'hFF;
            fifo_full <= q_full_next;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule
